regfile_param_sb: RTL and testbench
===================================

// Module: regfile_param_sb
// PURPOSE
//  Parametrised integer register file for the RISC-V core: NUM_READ async read ports, one write port, x0 hardwired to 0.
//  Self-initialising: after reset a clear FSM zeroes every entry one per cycle, so the array maps to block RAM with no multi-entry reset.
//  Built-in pending-write scoreboard lets decode stall on RAW hazards; optional same-cycle write-to-read bypass.
//  Sits between decode (read and issue side) and writeback (write side).
// PARAMETERS
//  XLEN      32  data width in bits
//  DEPTH     32  number of registers; power of two, >=2
//  NUM_READ  2   number of read ports, 1..4
//  ADDR_W    -   localparam = $clog2(DEPTH)
// PORTS
//  clk             in   1                one clock, rising edge
//  reset           in   1                synchronous, active-high
//  rs_addr         in   NUM_READ*ADDR_W  packed read addresses; port i = [i*ADDR_W +: ADDR_W]
//  rs_veri_o       out  NUM_READ*XLEN    packed read data; port i = [i*XLEN +: XLEN]
//  rs_pending_o    out  NUM_READ         1 = read port i targets a register with an outstanding write
//  rd              in   ADDR_W           write address
//  rd_veri         in   XLEN             write data
//  yazma_denetimi  in   1                write enable
//  sb_set          in   1                issue: mark sb_rd as pending
//  sb_rd           in   ADDR_W           issue destination register
//  init_busy_o     out  1                1 while the clear FSM runs; core must hold off issue
// BEHAVIOUR
//  Reset: reset is sampled on the clk edge only.
//   - FSM -> INIT, clear pointer ptr -> 1, all pending bits -> 0, init_busy_o -> 1.
//   - Array contents are not reset directly.
//  FSM:
//   - INIT: each cycle mem[ptr] <= 0, ptr <= ptr+1.
//   - When the write to ptr = DEPTH-1 occurs, go to READY; init_busy_o = 0 from the next cycle.
//   - Busy lasts exactly DEPTH-1 cycles after the reset cycle.
//   - READY: terminal until the next reset.
//   - Reset asserted in any state (including mid-INIT) restarts INIT from ptr=1.
//  During INIT: yazma_denetimi and sb_set are ignored. All rs_veri_o = 0, all rs_pending_o = 0.
//  Read (READY):
//   - Combinational; rs_veri_o[i] = 0 if addr_i == 0, else mem[addr_i].
//   - A write is visible on reads from the cycle after its clk edge.
//  Write (READY): at clk, if yazma_denetimi && rd != 0 then mem[rd] <= rd_veri. Writes to x0 are discarded.
//  Scoreboard pend[DEPTH-1:0], pend[0] is constant 0. Per index k != 0 at clk:
//   - set   = sb_set && sb_rd == k
//   - clr   = yazma_denetimi && rd == k
//   - pend[k] <= set ? 1 : (clr ? 0 : pend[k])
//   - Set and clear on the same index in the same cycle: set wins (newer issue supersedes the retiring write).
//  rs_pending_o[i] = pend[addr_i], subject to the bypass masking below.
//  No width conversion; rd_veri is stored verbatim, with no sign or zero extension.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   - If READY, yazma_denetimi=1, rd != 0 and addr_i == rd, then rs_veri_o[i] = rd_veri in the same cycle
//     and rs_pending_o[i] = 0 in that cycle.
//   - Adds a comparator and mux per read port.
//  REGFILE_BYPASS_EN undefined:
//   - Same-cycle reads return the old mem value and pend as stored; the new value is visible next cycle.
// TESTING (defaults XLEN=32, DEPTH=32, NUM_READ=2)
//  1 Init: pulse reset 1 cycle -> init_busy_o=1 for exactly 31 cycles; rs_veri_o=0 throughout;
//    afterwards all regs read 0x00000000.
//  2 Basic R/W: write x5=0x12345678 -> next cycle rs_addr port0=5 reads 0x12345678;
//    port1=6 reads 0x00000000.
//  3 x0: write x0=0xFFFFFFFF and sb_set sb_rd=0 -> x0 reads 0; rs_pending_o for addr 0 stays 0.
//  4 Bypass: x7 holds 0x11111111; write x7=0xA5A5A5A5 while port0 addr=7 ->
//    with REGFILE_BYPASS_EN port0 = 0xA5A5A5A5 that cycle; without it port0 = 0x11111111, then 0xA5A5A5A5 next cycle.
//  5 Scoreboard: sb_set x3 -> rs_pending_o=1 for addr 3; write x3 together with sb_set x3 -> pending stays 1;
//    a lone write x3 -> pending 0 next cycle.
//  6 Reset mid-INIT: reassert reset when ptr=10 -> busy restarts, 31 more busy cycles;
//    a write or sb_set issued during INIT has no effect.

Source files
------------

// File: rtl/regfile_param_sb_if.sv
// Register-file bus: decode read/issue side plus writeback write side.
// Clock and reset stay plain ports on the register file itself.
interface regfile_param_sb_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_READ = 2
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [NUM_READ*ADDR_W-1:0] rs_addr;
    logic [NUM_READ*XLEN-1:0]   rs_veri_o;
    logic [NUM_READ-1:0]        rs_pending_o;
    logic [ADDR_W-1:0]          rd;
    logic [XLEN-1:0]            rd_veri;
    logic                       yazma_denetimi;
    logic                       sb_set;
    logic [ADDR_W-1:0]          sb_rd;
    logic                       init_busy_o;

    modport master (
        output rs_addr, rd, rd_veri, yazma_denetimi, sb_set, sb_rd,
        input  rs_veri_o, rs_pending_o, init_busy_o
    );

    modport slave (
        input  rs_addr, rd, rd_veri, yazma_denetimi, sb_set, sb_rd,
        output rs_veri_o, rs_pending_o, init_busy_o
    );
endinterface

// File: rtl/regfile_param_sb.sv
// Self-initialising integer register file with x0 hardwired to zero and a pending-write scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_param_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_READ = 2
) (
    input  logic               clk,
    input  logic               reset,
    regfile_param_sb_if.slave  bus
);
    localparam int unsigned       ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_READY} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [XLEN-1:0]   mem [DEPTH];

    logic                       ready_c;
    logic                       wr_en_c;
    logic [ADDR_W-1:0]          raddr_c [NUM_READ];
    logic [NUM_READ*XLEN-1:0]   rs_data_c;
    logic [NUM_READ-1:0]        rs_pend_c;

    assign ready_c = (state_q == ST_READY);
    assign wr_en_c = ready_c && bus.yazma_denetimi && (bus.rd != '0);

    // Clear sweep walks ptr from 1 to DEPTH-1, then parks in READY until the next reset.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            ptr_q   <= ADDR_W'(1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // No reset on the array so it can map onto block RAM; the sweep provides the zeroing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_INIT) begin
                mem[ptr_q] <= '0;
            end else if (wr_en_c) begin
                mem[bus.rd] <= bus.rd_veri;
            end
        end
    end

    // A new issue to the same register outranks the write that retires the older one.
    always_comb begin
        pend_d = pend_q;
        if (ready_c) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (bus.sb_set && (bus.sb_rd == ADDR_W'(k))) begin
                    pend_d[k] = 1'b1;
                end else if (bus.yazma_denetimi && (bus.rd == ADDR_W'(k))) begin
                    pend_d[k] = 1'b0;
                end
            end
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_raddr
        assign raddr_c[g] = bus.rs_addr[g*ADDR_W +: ADDR_W];
    end

    always_comb begin
        rs_data_c = '0;
        rs_pend_c = '0;
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            if (ready_c && (raddr_c[i] != '0)) begin
                rs_data_c[i*XLEN +: XLEN] = mem[raddr_c[i]];
                rs_pend_c[i]              = pend_q[raddr_c[i]];
`ifdef REGFILE_BYPASS_EN
                if (wr_en_c && (raddr_c[i] == bus.rd)) begin
                    rs_data_c[i*XLEN +: XLEN] = bus.rd_veri;
                    rs_pend_c[i]              = 1'b0;
                end
`endif
            end
        end
    end

    assign bus.rs_veri_o    = rs_data_c;
    assign bus.rs_pending_o = rs_pend_c;
    assign bus.init_busy_o  = (state_q == ST_INIT);
endmodule

// File: tb/tb_regfile_param_sb.sv
// Bench for regfile_param_sb: array/counter reference model checked every cycle plus directed literal checks.
module tb_regfile_param_sb;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 32;
    localparam int unsigned NUM_READ = 2;
    localparam int unsigned ADDR_W   = 5;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    regfile_param_sb_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_READ(NUM_READ)) bus ();

    regfile_param_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_READ(NUM_READ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: busy cycles remaining, register values and pending flags.
    int          m_cnt = 0;
    logic [31:0] m_mem [DEPTH];
    bit          m_pend [DEPTH];

    always @(posedge clk) begin
        if (reset) begin
            m_cnt <= DEPTH - 1;
            for (int k = 0; k < DEPTH; k++) begin
                m_mem[k]  <= 32'h0;
                m_pend[k] <= 1'b0;
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                if (bus.sb_set && bus.sb_rd == 5'(k)) m_pend[k] <= 1'b1;
                else if (bus.yazma_denetimi && bus.rd == 5'(k)) m_pend[k] <= 1'b0;
            end
            if (bus.yazma_denetimi && bus.rd != 5'd0) m_mem[bus.rd] <= bus.rd_veri;
        end
    end

    function automatic void model_out(input int i, output logic [31:0] d, output logic p);
        logic [4:0] a;
        a = bus.rs_addr[i*ADDR_W +: ADDR_W];
        d = 32'h0;
        p = 1'b0;
        if (m_cnt == 0 && a != 5'd0) begin
            d = m_mem[a];
            p = m_pend[a];
`ifdef REGFILE_BYPASS_EN
            if (bus.yazma_denetimi && bus.rd == a) begin
                d = bus.rd_veri;
                p = 1'b0;
            end
`endif
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] d;
            logic        p;
            check("model_busy", 32'(bus.init_busy_o), 32'(m_cnt != 0));
            for (int i = 0; i < NUM_READ; i++) begin
                model_out(i, d, p);
                check("model_data", bus.rs_veri_o[i*XLEN +: XLEN], d);
                check("model_pend", 32'(bus.rs_pending_o[i]), 32'(p));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int a0, input int a1);
        bus.rs_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic clear_ctl();
        bus.yazma_denetimi = 1'b0;
        bus.sb_set         = 1'b0;
    endtask

    function automatic logic [31:0] port(input int i);
        return bus.rs_veri_o[i*XLEN +: XLEN];
    endfunction

    initial begin
        int n;
        reset              = 1'b1;
        bus.rs_addr        = '0;
        bus.rd             = '0;
        bus.rd_veri        = '0;
        bus.yazma_denetimi = 1'b0;
        bus.sb_set         = 1'b0;
        bus.sb_rd          = '0;

        // Power-up init sweep.
        step();
        chk_en = 1'b1;
        reset  = 1'b0;
        set_addr(5, 31);
        #2;
        check("init_busy_start", 32'(bus.init_busy_o), 32'd1);
        check("init_read_zero", port(0), 32'h0);
        n = 0;
        while (bus.init_busy_o && n < 100) begin
            n++;
            step();
        end
        check("init_busy_len", 32'(n), 32'd31);

        for (int a = 0; a < DEPTH; a += 2) begin
            set_addr(a, a + 1);
            #2;
            check("post_init_p0", port(0), 32'h0);
            check("post_init_p1", port(1), 32'h0);
            step();
        end

        // Basic write then read.
        bus.yazma_denetimi = 1'b1; bus.rd = 5'd5; bus.rd_veri = 32'h12345678;
        step();
        clear_ctl();
        set_addr(5, 6);
        #2;
        check("rw_x5", port(0), 32'h12345678);
        check("rw_x6", port(1), 32'h0);

        // x0 writes and issues are discarded.
        bus.yazma_denetimi = 1'b1; bus.rd = 5'd0; bus.rd_veri = 32'hFFFFFFFF;
        bus.sb_set = 1'b1; bus.sb_rd = 5'd0;
        set_addr(0, 0);
        step();
        clear_ctl();
        #2;
        check("x0_data", port(0), 32'h0);
        check("x0_pend", 32'(bus.rs_pending_o[0]), 32'd0);

        // Same-cycle write/read of x7.
        bus.yazma_denetimi = 1'b1; bus.rd = 5'd7; bus.rd_veri = 32'h11111111;
        step();
        bus.rd_veri = 32'hA5A5A5A5;
        set_addr(7, 5);
        #2;
`ifdef REGFILE_BYPASS_EN
        check("bypass_same", port(0), 32'hA5A5A5A5);
`else
        check("bypass_same", port(0), 32'h11111111);
`endif
        step();
        clear_ctl();
        #2;
        check("bypass_next", port(0), 32'hA5A5A5A5);

        // Scoreboard set / set-wins / clear on x3.
        bus.sb_set = 1'b1; bus.sb_rd = 5'd3;
        step();
        clear_ctl();
        set_addr(5, 3);
        #2;
        check("sb_set", 32'(bus.rs_pending_o[1]), 32'd1);
        bus.yazma_denetimi = 1'b1; bus.rd = 5'd3; bus.rd_veri = 32'hCAFE0003;
        bus.sb_set = 1'b1; bus.sb_rd = 5'd3;
        step();
        clear_ctl();
        #2;
        check("sb_set_wins", 32'(bus.rs_pending_o[1]), 32'd1);
        check("sb_x3_data", port(1), 32'hCAFE0003);
        bus.yazma_denetimi = 1'b1; bus.rd = 5'd3; bus.rd_veri = 32'hBEEF0003;
        #2;
`ifdef REGFILE_BYPASS_EN
        check("sb_clr_same", 32'(bus.rs_pending_o[1]), 32'd0);
`else
        check("sb_clr_same", 32'(bus.rs_pending_o[1]), 32'd1);
`endif
        step();
        clear_ctl();
        #2;
        check("sb_clr_next", 32'(bus.rs_pending_o[1]), 32'd0);
        check("sb_x3_new", port(1), 32'hBEEF0003);

        // Reset reasserted mid-sweep; traffic during INIT must be ignored.
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        bus.yazma_denetimi = 1'b1; bus.rd = 5'd9; bus.rd_veri = 32'hDEADBEEF;
        bus.sb_set = 1'b1; bus.sb_rd = 5'd9;
        step();
        reset = 1'b0;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            if (bus.init_busy_o) n++;
            step();
        end
        clear_ctl();
        while (bus.init_busy_o && n < 100) begin
            n++;
            step();
        end
        check("reinit_busy_len", 32'(n), 32'd31);
        set_addr(9, 5);
        #2;
        check("reinit_x9", port(0), 32'h0);
        check("reinit_x9_pend", 32'(bus.rs_pending_o[0]), 32'd0);
        check("reinit_x5", port(1), 32'h0);
        set_addr(7, 3);
        #2;
        check("reinit_x7", port(0), 32'h0);
        check("reinit_x3", port(1), 32'h0);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
